nave_ctrl: RTL and testbench
============================

Name: nave_ctrl

Overview:
Parametrised player-ship controller for the game datapath; successor to the fixed-size, one-pixel-per-clock ship block. Adds a step-rate divider, screen-edge clamping, a speed ramp while a direction is held, and an edge-triggered ball-launch FSM with a life counter and game-over state. Sits between the key debouncer (keysout) and the ball/renderer blocks. Drives the ship rectangle position and the ball-start level.

Parameters:
SCREEN_W, 640, visible width in pixels
SHIP_W, 30, ship width (driven on largura_nave)
SHIP_H, 30, ship height (driven on altura_nave)
X_INIT, 350, x_nave after reset/restart
Y_INIT, 420, y_nave after reset/restart (constant thereafter)
STEP_DIV, 250000, clocks per movement step (>=2)
ACCEL_STEPS, 8, consecutive held steps per speed increment
SPEED_MAX, 4, max pixels per step (1..15)
VIDAS_INIT, 3, lives at start (1..15)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
keysout  in  4  [0]=right, [1]=left, [2]=launch, [3]=reserved (ignored)
pausa  in  1  1 = freeze all state
reiniciarJogo  in  1  synchronous game restart
bateu  in  1  ball lost (one-cycle pulse from ball block)
iniciarBola  out  1  1 while ball in flight
largura_nave  out  10  constant SHIP_W
altura_nave  out  10  constant SHIP_H
x_nave  out  10  ship left x
y_nave  out  10  ship top y
vidas  out  4  remaining lives
fim_jogo  out  1  1 in game-over state

Behaviour:
- Reset (reset=0, async): x_nave=X_INIT, y_nave=Y_INIT, iniciarBola=0, vidas=VIDAS_INIT, fim_jogo=0, state=AGUARDA, speed=1, tick counter=0, held-step counter=0, launch-key history=0.
- reiniciarJogo=1 (sync, priority over everything except reset): same values as reset, applied on the next edge.
- pausa=1: all registers hold. Tick counter frozen. bateu and launch edges ignored (not queued). Launch-key history still sampled so a press held through pause does not fire on release of pausa.
- Tick: counter 0..STEP_DIV-1. Step fires on the edge where the counter==STEP_DIV-1; the counter then wraps to 0.
- Movement (on step only):
  - right-only: x = min(x+speed, SCREEN_W-SHIP_W).
  - left-only: x = (x<speed) ? 0 : x-speed.
  - Compute in 11 bits; no wrap-around ever.
  - Both keys or neither: no move; speed=1; held counter=0.
- Speed ramp:
  - Same direction as previous step: held counter +1.
  - When the counter reaches ACCEL_STEPS: speed = min(speed+1, SPEED_MAX) and the counter clears.
  - Direction change: speed=1 and counter=0 before this step's move, so the move uses 1.
- FSM (state encoding from package):
  - AGUARDA: iniciarBola=0. Rising edge of keysout[2] (current=1, previous=0) -> ATIVO; iniciarBola=1 from the next edge. bateu ignored.
  - ATIVO: iniciarBola=1. Launch edges ignored. bateu=1 -> vidas-1. If vidas was 1: -> FIM, vidas=0, fim_jogo=1; else -> AGUARDA.
  - FIM: iniciarBola=0, fim_jogo=1. Movement is disabled. Exit only via reiniciarJogo or reset.
- Movement is permitted in AGUARDA and ATIVO.
- A bateu in the same cycle as a launch edge in AGUARDA: launch wins; bateu is dropped.

Decomposition:
- Shared package nave_pkg:
  - state enum {AGUARDA, ATIVO, FIM};
  - key index constants KEY_DIR=0, KEY_ESQ=1, KEY_LANCA=2;
  - coordinate width constant COORD_W=10.
- Sub-module nave_tick: parametrised STEP_DIV divider with enable (=!pausa), sync clear, one-cycle step output.

Test Plan:
- Reset, then release with default params -> x_nave=350, y_nave=420, vidas=3, iniciarBola=0, fim_jogo=0.
- STEP_DIV=4; hold right 2 steps -> x 350->351->352, each change exactly 4 clocks apart. Hold long enough with ACCEL_STEPS=2, SPEED_MAX=4 -> increments become 2, then 3, then 4 and stay at 4.
- Edge clamp: x=605, speed=4, right held -> x_nave=610 (=640-30) and stays. x=2, speed=4, left held -> 0.
- Both keys held -> no change, speed back to 1. Direction reversal at speed 3 -> first reverse step moves 1.
- Launch/lives: key2 rise -> iniciarBola=1 next edge. Holding key2 gives no retrigger. Three bateu pulses, each followed by a relaunch -> vidas 2, 1, 0; fim_jogo=1; key2 then ignored; reiniciarJogo -> vidas=3, x=350.
- pausa=1 with right held and bateu pulsed -> x, vidas, tick all frozen. Assert reset mid-step -> immediate async return to reset values.

Source files
------------

// File: rtl/nave_pkg.sv
// Shared types, key indices and saturating move helpers for the player-ship controller.
package nave_pkg;

   localparam int COORD_W   = 10;
   localparam int KEY_DIR   = 0;
   localparam int KEY_ESQ   = 1;
   localparam int KEY_LANCA = 2;

   typedef enum logic [1:0] {
      AGUARDA = 2'd0,
      ATIVO   = 2'd1,
      FIM     = 2'd2
   } estado_e;

   typedef enum logic [1:0] {
      DIR_NENHUMA  = 2'd0,
      DIR_DIREITA  = 2'd1,
      DIR_ESQUERDA = 2'd2
   } dir_e;

   // Right move clamped at lim; the sum is one bit wider so it can never wrap.
   function automatic logic [COORD_W-1:0] mover_dir(input logic [COORD_W-1:0] x,
                                                    input logic [3:0]         spd,
                                                    input logic [COORD_W:0]   lim);
      logic [COORD_W:0] soma;
      soma = {1'b0, x} + {{(COORD_W-3){1'b0}}, spd};
      if (soma > lim) begin
         mover_dir = lim[COORD_W-1:0];
      end else begin
         mover_dir = soma[COORD_W-1:0];
      end
   endfunction

   function automatic logic [COORD_W-1:0] mover_esq(input logic [COORD_W-1:0] x,
                                                    input logic [3:0]         spd);
      logic [COORD_W:0] xw;
      logic [COORD_W:0] sw;
      xw = {1'b0, x};
      sw = {{(COORD_W-3){1'b0}}, spd};
      if (xw < sw) begin
         mover_esq = {COORD_W{1'b0}};
      end else begin
         xw        = xw - sw;
         mover_esq = xw[COORD_W-1:0];
      end
   endfunction

endpackage

// File: rtl/nave_tick.sv
// Movement step-rate divider: counts 0..STEP_DIV-1 while enabled and flags the wrap cycle.
module nave_tick #(
   parameter int STEP_DIV = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic srst,
   input  logic en,
   output logic step
);

   localparam int               CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int               CNT_TOP = STEP_DIV - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_TOP[CNT_W-1:0];

   logic [CNT_W-1:0] cnt_r;

   // Free-running divider, frozen while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (srst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (en) begin
         if (cnt_r == CNT_MAX) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + 1'b1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign step = en && (cnt_r == CNT_MAX);

endmodule

// File: rtl/nave_ctrl.sv
// Player-ship controller: stepped, clamped movement with a hold-to-accelerate ramp,
// and the ball-launch / lives state machine.
module nave_ctrl
   import nave_pkg::*;
#(
   parameter int SCREEN_W    = 640,
   parameter int SHIP_W      = 30,
   parameter int SHIP_H      = 30,
   parameter int X_INIT      = 350,
   parameter int Y_INIT      = 420,
   parameter int STEP_DIV    = 250000,
   parameter int ACCEL_STEPS = 8,
   parameter int SPEED_MAX   = 4,
   parameter int VIDAS_INIT  = 3
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [3:0]         keysout,
   input  logic               pausa,
   input  logic               reiniciarJogo,
   input  logic               bateu,
   output logic               iniciarBola,
   output logic [COORD_W-1:0] largura_nave,
   output logic [COORD_W-1:0] altura_nave,
   output logic [COORD_W-1:0] x_nave,
   output logic [COORD_W-1:0] y_nave,
   output logic [3:0]         vidas,
   output logic               fim_jogo
);

   localparam int                 X_LIM_I = SCREEN_W - SHIP_W;
   localparam logic [COORD_W:0]   X_LIM   = X_LIM_I[COORD_W:0];
   localparam logic [COORD_W-1:0] X_RST   = X_INIT[COORD_W-1:0];
   localparam logic [COORD_W-1:0] Y_RST   = Y_INIT[COORD_W-1:0];
   localparam logic [COORD_W-1:0] LARG    = SHIP_W[COORD_W-1:0];
   localparam logic [COORD_W-1:0] ALT     = SHIP_H[COORD_W-1:0];
   localparam logic [3:0]         VEL_MAX = SPEED_MAX[3:0];
   localparam logic [3:0]         VIDAS_V = VIDAS_INIT[3:0];
   localparam int                 CONT_W  = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS + 1) : 1;
   localparam int                 CONT_T  = ACCEL_STEPS - 1;
   localparam logic [CONT_W-1:0]  CONT_FIM = CONT_T[CONT_W-1:0];

   estado_e            estado_r, estado_s;
   logic               inicia_r, inicia_s;
   logic               fim_r, fim_s;
   logic [3:0]         vidas_r, vidas_s;
   logic               lanca_ant_r;
   logic               lanca_borda_s;
   logic               tick_en_s;
   logic               passo_s;
   logic               mover_ok_s;
   logic [COORD_W-1:0] x_r, x_s;
   logic [3:0]         vel_r, vel_s, vel_mov_s;
   logic [CONT_W-1:0]  cont_r, cont_s;
   dir_e               dir_ant_r, dir_s, dir_cmd_s;
   logic               reservado_unused_s;

   assign reservado_unused_s = keysout[3];
   assign tick_en_s          = ~pausa;
   assign lanca_borda_s      = keysout[KEY_LANCA] & ~lanca_ant_r;
   assign mover_ok_s         = passo_s && (estado_r != FIM);

   nave_tick #(
      .STEP_DIV (STEP_DIV)
   ) u_tick (
      .clk   (CLOCK_50),
      .rst_n (reset),
      .srst  (reiniciarJogo),
      .en    (tick_en_s),
      .step  (passo_s)
   );

   // Launch-key history keeps sampling during pause so a held key never looks like a new press.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         lanca_ant_r <= 1'b0;
      end else if (reiniciarJogo) begin
         lanca_ant_r <= 1'b0;
      end else begin
         lanca_ant_r <= keysout[KEY_LANCA];
      end
   end

   // State register; the flag outputs are registered from the next state so they move with it.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         estado_r <= AGUARDA;
         vidas_r  <= VIDAS_V;
         inicia_r <= 1'b0;
         fim_r    <= 1'b0;
      end else if (reiniciarJogo) begin
         estado_r <= AGUARDA;
         vidas_r  <= VIDAS_V;
         inicia_r <= 1'b0;
         fim_r    <= 1'b0;
      end else begin
         estado_r <= estado_s;
         vidas_r  <= vidas_s;
         inicia_r <= inicia_s;
         fim_r    <= fim_s;
      end
   end

   // Next state: a launch edge in AGUARDA wins over a simultaneous bateu.
   always_comb begin
      estado_s = estado_r;
      vidas_s  = vidas_r;
      if (pausa) begin
         estado_s = estado_r;
         vidas_s  = vidas_r;
      end else begin
         case (estado_r)
            AGUARDA: begin
               if (lanca_borda_s) begin
                  estado_s = ATIVO;
               end else begin
                  estado_s = AGUARDA;
               end
            end
            ATIVO: begin
               if (bateu) begin
                  if (vidas_r == 4'd1) begin
                     estado_s = FIM;
                     vidas_s  = 4'd0;
                  end else begin
                     estado_s = AGUARDA;
                     vidas_s  = vidas_r - 4'd1;
                  end
               end else begin
                  estado_s = ATIVO;
               end
            end
            FIM:     estado_s = FIM;
            default: estado_s = AGUARDA;
         endcase
      end
   end

   // Output decode of the next state.
   always_comb begin
      inicia_s = 1'b0;
      fim_s    = 1'b0;
      case (estado_s)
         AGUARDA: begin
            inicia_s = 1'b0;
            fim_s    = 1'b0;
         end
         ATIVO:   inicia_s = 1'b1;
         FIM:     fim_s    = 1'b1;
         default: begin
            inicia_s = 1'b0;
            fim_s    = 1'b0;
         end
      endcase
   end

   always_comb begin
      case ({keysout[KEY_ESQ], keysout[KEY_DIR]})
         2'b01:   dir_cmd_s = DIR_DIREITA;
         2'b10:   dir_cmd_s = DIR_ESQUERDA;
         default: dir_cmd_s = DIR_NENHUMA;
      endcase
   end

   // Movement and speed ramp. A step moves by the speed held so far; an increment applies from the next step.
   always_comb begin
      x_s       = x_r;
      vel_s     = vel_r;
      cont_s    = cont_r;
      dir_s     = dir_ant_r;
      vel_mov_s = 4'd1;
      if (mover_ok_s) begin
         if (dir_cmd_s == DIR_NENHUMA) begin
            vel_s  = 4'd1;
            cont_s = {CONT_W{1'b0}};
            dir_s  = DIR_NENHUMA;
         end else begin
            if (dir_cmd_s == dir_ant_r) begin
               vel_mov_s = vel_r;
               if (cont_r == CONT_FIM) begin
                  vel_s  = (vel_r < VEL_MAX) ? (vel_r + 4'd1) : VEL_MAX;
                  cont_s = {CONT_W{1'b0}};
               end else begin
                  cont_s = cont_r + 1'b1;
               end
            end else begin
               vel_mov_s = 4'd1;
               vel_s     = 4'd1;
               cont_s    = {CONT_W{1'b0}};
            end
            dir_s = dir_cmd_s;
            if (dir_cmd_s == DIR_DIREITA) begin
               x_s = mover_dir(x_r, vel_mov_s, X_LIM);
            end else begin
               x_s = mover_esq(x_r, vel_mov_s);
            end
         end
      end else begin
         x_s   = x_r;
         vel_s = vel_r;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         x_r       <= X_RST;
         vel_r     <= 4'd1;
         cont_r    <= {CONT_W{1'b0}};
         dir_ant_r <= DIR_NENHUMA;
      end else if (reiniciarJogo) begin
         x_r       <= X_RST;
         vel_r     <= 4'd1;
         cont_r    <= {CONT_W{1'b0}};
         dir_ant_r <= DIR_NENHUMA;
      end else begin
         x_r       <= x_s;
         vel_r     <= vel_s;
         cont_r    <= cont_s;
         dir_ant_r <= dir_s;
      end
   end

   assign iniciarBola  = inicia_r;
   assign fim_jogo     = fim_r;
   assign vidas        = vidas_r;
   assign x_nave       = x_r;
   assign y_nave       = Y_RST;
   assign largura_nave = LARG;
   assign altura_nave  = ALT;

endmodule

// File: tb/tb_nave_ctrl.sv
// Directed bench for nave_ctrl with a cycle-level integer model and literal pins.
module tb_nave_ctrl;

   localparam int STEP_DIV = 4;
   localparam int ACCEL    = 2;
   localparam int SMAX     = 4;
   localparam int XLIM     = 640 - 30;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] keysout = 4'b0000;
   logic       pausa = 1'b0;
   logic       reiniciarJogo = 1'b0;
   logic       bateu = 1'b0;
   logic       iniciarBola;
   logic [9:0] largura_nave, altura_nave, x_nave, y_nave;
   logic [3:0] vidas;
   logic       fim_jogo;

   int n_checks = 0;
   int n_errors = 0;

   // model: state 0 = waiting, 1 = ball in flight, 2 = game over
   int m_x, m_spd, m_held, m_prev, m_lives, m_state, m_tick;
   bit m_hist;

   always #5 clk = ~clk;

   nave_ctrl #(
      .STEP_DIV    (STEP_DIV),
      .ACCEL_STEPS (ACCEL),
      .SPEED_MAX   (SMAX)
   ) dut (
      .CLOCK_50      (clk),
      .reset         (reset),
      .keysout       (keysout),
      .pausa         (pausa),
      .reiniciarJogo (reiniciarJogo),
      .bateu         (bateu),
      .iniciarBola   (iniciarBola),
      .largura_nave  (largura_nave),
      .altura_nave   (altura_nave),
      .x_nave        (x_nave),
      .y_nave        (y_nave),
      .vidas         (vidas),
      .fim_jogo      (fim_jogo)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act != exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = 350; m_spd = 1; m_held = 0; m_prev = 0;
      m_lives = 3; m_state = 0; m_tick = 0; m_hist = 1'b0;
   endtask

   task automatic model_edge();
      int  dir;
      int  mv;
      bit  stp;
      bit  rise;
      if (!reset || reiniciarJogo) begin
         model_reset();
         return;
      end
      if (!pausa) begin
         stp    = (m_tick == STEP_DIV - 1);
         m_tick = stp ? 0 : m_tick + 1;
         rise   = keysout[2] && !m_hist;
         if (stp && m_state != 2) begin
            if (keysout[0] && !keysout[1])      dir = 1;
            else if (keysout[1] && !keysout[0]) dir = 2;
            else                                dir = 0;
            if (dir == 0) begin
               m_spd = 1; m_held = 0;
            end else begin
               if (dir != m_prev) begin
                  m_spd = 1; m_held = 0; mv = 1;
               end else begin
                  mv = m_spd;
                  m_held = m_held + 1;
                  if (m_held == ACCEL) begin
                     m_spd  = (m_spd < SMAX) ? m_spd + 1 : SMAX;
                     m_held = 0;
                  end
               end
               if (dir == 1) m_x = (m_x + mv > XLIM) ? XLIM : m_x + mv;
               else          m_x = (m_x < mv) ? 0 : m_x - mv;
            end
            m_prev = dir;
         end
         if (m_state == 0 && rise) begin
            m_state = 1;
         end else if (m_state == 1 && bateu) begin
            m_lives = m_lives - 1;
            m_state = (m_lives == 0) ? 2 : 0;
         end
      end
      m_hist = keysout[2];
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   // Compare process: every falling edge, outputs against the model.
   always @(negedge clk) begin
      chk("x_nave", int'(x_nave), m_x);
      chk("y_nave", int'(y_nave), 420);
      chk("vidas", int'(vidas), m_lives);
      chk("iniciarBola", int'(iniciarBola), (m_state == 1) ? 1 : 0);
      chk("fim_jogo", int'(fim_jogo), (m_state == 2) ? 1 : 0);
      chk("largura", int'(largura_nave), 30);
      chk("altura", int'(altura_nave), 30);
   end

   task automatic espera(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulso_bateu();
      bateu = 1'b1;
      espera(1);
      bateu = 1'b0;
   endtask

   initial begin
      model_reset();
      espera(2);
      chk("rst_x", int'(x_nave), 350);
      chk("rst_vidas", int'(vidas), 3);
      chk("rst_ini", int'(iniciarBola), 0);
      reset   = 1'b1;
      keysout = 4'b0001;
      espera(3);  chk("step_not_yet", int'(x_nave), 350);
      espera(1);  chk("step1", int'(x_nave), 351);
      espera(4);  chk("step2", int'(x_nave), 352);
      espera(16); chk("ramp_s6", int'(x_nave), 360);
      espera(8);  chk("ramp_s8", int'(x_nave), 367);
      espera(4);  chk("ramp_max", int'(x_nave), 371);
      espera(4 * 69); chk("clamp_right", int'(x_nave), 610);
      keysout = 4'b0010;
      espera(4);  chk("reverse_first", int'(x_nave), 609);
      espera(4 * 200); chk("clamp_left", int'(x_nave), 0);
      keysout = 4'b0011;
      espera(4);  chk("both_keys", int'(x_nave), 0);
      keysout = 4'b0001;
      espera(4);  chk("speed_reset", int'(x_nave), 1);
      keysout = 4'b0100;
      espera(1);  chk("launch", int'(iniciarBola), 1);
      espera(3);
      pulso_bateu();
      chk("vidas_2", int'(vidas), 2);
      espera(2);  chk("held_no_retrigger", int'(iniciarBola), 0);
      keysout = 4'b0000; espera(1);
      keysout = 4'b0100; espera(1);
      chk("relaunch", int'(iniciarBola), 1);
      pulso_bateu();
      chk("vidas_1", int'(vidas), 1);
      keysout = 4'b0000; espera(1);
      keysout = 4'b0100; espera(1);
      pulso_bateu();
      chk("vidas_0", int'(vidas), 0);
      chk("fim", int'(fim_jogo), 1);
      keysout = 4'b0000; espera(1);
      keysout = 4'b0101; espera(8);
      chk("fim_ignores_launch", int'(iniciarBola), 0);
      chk("fim_no_move", int'(x_nave), 1);
      reiniciarJogo = 1'b1; espera(1);
      reiniciarJogo = 1'b0;
      chk("restart_vidas", int'(vidas), 3);
      chk("restart_x", int'(x_nave), 350);
      chk("restart_fim", int'(fim_jogo), 0);
      keysout = 4'b0100;
      bateu   = 1'b1; espera(1); bateu = 1'b0;
      chk("launch_wins_ini", int'(iniciarBola), 1);
      chk("launch_wins_vidas", int'(vidas), 3);
      keysout = 4'b0101;
      pausa   = 1'b1;
      espera(2);
      pulso_bateu();
      espera(10);
      chk("pause_x", int'(x_nave), 350);
      chk("pause_vidas", int'(vidas), 3);
      pausa   = 1'b0;
      keysout = 4'b0000;
      pulso_bateu();
      chk("unpause_bateu", int'(vidas), 2);
      pausa   = 1'b1;
      keysout = 4'b0100;
      espera(3);
      pausa   = 1'b0;
      espera(3);
      chk("pause_held_launch", int'(iniciarBola), 0);
      keysout = 4'b0001;
      espera(2);
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      espera(1);
      chk("async_reset_x", int'(x_nave), 350);
      chk("async_reset_vidas", int'(vidas), 3);
      espera(1);
      reset = 1'b1;
      espera(12);
      chk("post_reset", int'(x_nave), 353);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
